// File: rtl/ann_pkg.sv
// Shared definitions for the ANN layer-sequencing controller: FSM encoding,
// default layer latencies and the counter preload helper.
package ann_pkg;

  localparam int LAT_W       = 4;
  localparam int DEF_LAT_IN  = 1;
  localparam int DEF_LAT_HID = 2;
  localparam int DEF_LAT_OUT = 2;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RUN_IN  = 3'd1,
    ST_RUN_HID = 3'd2,
    ST_RUN_OUT = 3'd3,
    ST_HOLD    = 3'd4
  } state_e;

  // A layer of latency N occupies N cycles, so the down-counter starts at N-1.
  function automatic logic [LAT_W-1:0] lat_load(input int lat);
    logic [LAT_W-1:0] val;
    val = LAT_W'(lat - 1);
    return val;
  endfunction

endpackage

// File: rtl/ann_ctrl_lat_counter.sv
// Per-state latency down-counter: loads on state entry, counts to zero and
// holds there; the zero flag tells the FSM the current layer is finished.
module lat_counter
  import ann_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [LAT_W-1:0] load_val,
  output logic [LAT_W-1:0] value,
  output logic             zero
);

  logic [LAT_W-1:0] cnt_q;
  logic [LAT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - LAT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign value = cnt_q;
  assign zero  = (cnt_q == '0);

endmodule

// File: rtl/ann_ctrl.sv
// Sequencer for a three-layer ANN datapath: accepts one sample, strobes each
// layer for its latency, then holds the result until taken. Optional
// completed-handshake counter enabled by defining ANN_CTRL_PERF_EN.
module ann_ctrl
  import ann_pkg::*;
#(
  parameter int DWIDTH  = 32,
  parameter int LAT_IN  = DEF_LAT_IN,
  parameter int LAT_HID = DEF_LAT_HID,
  parameter int LAT_OUT = DEF_LAT_OUT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DWIDTH-1:0] in_a,
  input  logic [DWIDTH-1:0] in_b,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DWIDTH-1:0] dp_a,
  output logic [DWIDTH-1:0] dp_b,
  output logic              en_in,
  output logic              en_hid,
  output logic              en_out,
  input  logic [DWIDTH-1:0] dp_out1,
  input  logic [DWIDTH-1:0] dp_out2,
  output logic [DWIDTH-1:0] res1,
  output logic [DWIDTH-1:0] res2,
  output logic              res_valid,
  input  logic              res_ready,
`ifdef ANN_CTRL_PERF_EN
  output logic [31:0]       perf_cnt,
`endif
  output logic              busy
);

  state_e state_q;
  state_e state_d;

  logic             cnt_load;
  logic [LAT_W-1:0] cnt_load_val;
  logic [LAT_W-1:0] unused_cnt_value;
  logic             cnt_zero;

  logic [DWIDTH-1:0] dp_a_q, dp_a_d;
  logic [DWIDTH-1:0] dp_b_q, dp_b_d;
  logic [DWIDTH-1:0] res1_q, res1_d;
  logic [DWIDTH-1:0] res2_q, res2_d;
  logic              res_valid_q, res_valid_d;

  logic xfer;
  logic capture;
  logic done;

  assign xfer    = (state_q == ST_IDLE) && in_valid;
  assign capture = (state_q == ST_RUN_OUT) && cnt_zero;
  assign done    = (state_q == ST_HOLD) && res_ready;

  lat_counter u_lat_counter (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .value    (unused_cnt_value),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (in_valid)  state_d = ST_RUN_IN;
      ST_RUN_IN:  if (cnt_zero)  state_d = ST_RUN_HID;
      ST_RUN_HID: if (cnt_zero)  state_d = ST_RUN_OUT;
      ST_RUN_OUT: if (cnt_zero)  state_d = ST_HOLD;
      ST_HOLD:    if (res_ready) state_d = ST_IDLE;
      default:                   state_d = ST_IDLE;
    endcase
  end

  // Counter is preloaded on the same edge the FSM enters a new state.
  always_comb begin
    cnt_load     = (state_d != state_q);
    cnt_load_val = '0;
    case (state_d)
      ST_RUN_IN:  cnt_load_val = lat_load(LAT_IN);
      ST_RUN_HID: cnt_load_val = lat_load(LAT_HID);
      ST_RUN_OUT: cnt_load_val = lat_load(LAT_OUT);
      default:    cnt_load_val = '0;
    endcase
  end

  always_comb begin
    in_ready = 1'b0;
    en_in    = 1'b0;
    en_hid   = 1'b0;
    en_out   = 1'b0;
    busy     = 1'b1;
    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
      end
      ST_RUN_IN:  en_in  = 1'b1;
      ST_RUN_HID: en_hid = 1'b1;
      ST_RUN_OUT: en_out = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    dp_a_d      = dp_a_q;
    dp_b_d      = dp_b_q;
    res1_d      = res1_q;
    res2_d      = res2_q;
    res_valid_d = res_valid_q;
    if (xfer) begin
      dp_a_d = in_a;
      dp_b_d = in_b;
    end
    if (capture) begin
      res1_d      = dp_out1;
      res2_d      = dp_out2;
      res_valid_d = 1'b1;
    end else if (done) begin
      res_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dp_a_q      <= '0;
      dp_b_q      <= '0;
      res1_q      <= '0;
      res2_q      <= '0;
      res_valid_q <= 1'b0;
    end else begin
      dp_a_q      <= dp_a_d;
      dp_b_q      <= dp_b_d;
      res1_q      <= res1_d;
      res2_q      <= res2_d;
      res_valid_q <= res_valid_d;
    end
  end

  assign dp_a      = dp_a_q;
  assign dp_b      = dp_b_q;
  assign res1      = res1_q;
  assign res2      = res2_q;
  assign res_valid = res_valid_q;

`ifdef ANN_CTRL_PERF_EN
  logic [31:0] perf_cnt_q;
  logic [31:0] perf_cnt_d;

  always_comb begin
    perf_cnt_d = perf_cnt_q;
    if (done) begin
      perf_cnt_d = perf_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_cnt_q <= '0;
    end else begin
      perf_cnt_q <= perf_cnt_d;
    end
  end

  assign perf_cnt = perf_cnt_q;
`endif

endmodule

// File: tb/tb_ann_ctrl.sv
// Directed scoreboard bench for ann_ctrl: default-latency instance plus an
// all-ones-latency instance for back-to-back throughput.
module tb_ann_ctrl;

  logic        clk;
  logic        rst;
  logic [31:0] in_a, in_b, dp_out1, dp_out2;
  logic        in_valid, res_ready;
  logic        in_ready, en_in, en_hid, en_out, res_valid, busy;
  logic [31:0] dp_a, dp_b, res1, res2;

  logic [31:0] b_in_a, b_in_b, b_dp_out1, b_dp_out2;
  logic        b_in_valid, b_res_ready;
  logic        b_in_ready, b_en_in, b_en_hid, b_en_out, b_res_valid, b_busy;
  logic [31:0] b_dp_a, b_dp_b, b_res1, b_res2;

`ifdef ANN_CTRL_PERF_EN
  logic [31:0] perf_cnt;
  logic [31:0] b_perf_cnt;
`endif

  int checks   = 0;
  int failures = 0;
  int cnt_in, cnt_hid, cnt_out;

  typedef struct {
    logic [31:0] r1;
    logic [31:0] r2;
  } exp_t;
  exp_t sb[$];

  ann_ctrl dut (
    .clk(clk), .rst(rst), .in_a(in_a), .in_b(in_b), .in_valid(in_valid),
    .in_ready(in_ready), .dp_a(dp_a), .dp_b(dp_b), .en_in(en_in),
    .en_hid(en_hid), .en_out(en_out), .dp_out1(dp_out1), .dp_out2(dp_out2),
    .res1(res1), .res2(res2), .res_valid(res_valid), .res_ready(res_ready),
`ifdef ANN_CTRL_PERF_EN
    .perf_cnt(perf_cnt),
`endif
    .busy(busy)
  );

  ann_ctrl #(.DWIDTH(32), .LAT_IN(1), .LAT_HID(1), .LAT_OUT(1)) dut_b2b (
    .clk(clk), .rst(rst), .in_a(b_in_a), .in_b(b_in_b), .in_valid(b_in_valid),
    .in_ready(b_in_ready), .dp_a(b_dp_a), .dp_b(b_dp_b), .en_in(b_en_in),
    .en_hid(b_en_hid), .en_out(b_en_out), .dp_out1(b_dp_out1), .dp_out2(b_dp_out2),
    .res1(b_res1), .res2(b_res2), .res_valid(b_res_valid), .res_ready(b_res_ready),
`ifdef ANN_CTRL_PERF_EN
    .perf_cnt(b_perf_cnt),
`endif
    .busy(b_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Transfers one sample and runs until res_valid; returns edges counted
  // from the transfer edge (inclusive), 0 on timeout.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] o1, input logic [31:0] o2,
                               input bit toggle, output int lat);
    exp_t e;
    e.r1 = o1;
    e.r2 = o2;
    sb.push_back(e);
    in_a = a; in_b = b; dp_out1 = o1; dp_out2 = o2;
    res_ready = 1'b0;
    in_valid  = 1'b1;
    cnt_in = 0; cnt_hid = 0; cnt_out = 0;
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (toggle) begin
        in_valid = ~in_valid;
        in_a     = 32'hDEAD_BEEF;
      end else begin
        in_valid = 1'b0;
      end
      cnt_in  += int'(en_in);
      cnt_hid += int'(en_hid);
      cnt_out += int'(en_out);
      if (res_valid) begin
        lat = k;
        break;
      end
    end
  endtask

  // Holds res_ready low for stall cycles, then pops the scoreboard and takes the result.
  task automatic drainResult(input int stall, input logic [31:0] exp_dp_a);
    exp_t e;
    logic [31:0] r1_seen;
    r1_seen = res1;
    for (int i = 0; i < stall; i++) begin
      @(posedge clk);
      @(negedge clk);
      checkOutput("hold_res_valid", {31'd0, res_valid}, 32'd1);
      checkOutput("hold_res1", res1, r1_seen);
      checkOutput("hold_in_ready", {31'd0, in_ready}, 32'd0);
      checkOutput("hold_busy", {31'd0, busy}, 32'd1);
    end
    in_valid = 1'b0;
    checkOutput("sb_nonempty", sb.size(), 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checkOutput("res1", res1, e.r1);
      checkOutput("res2", res2, e.r2);
    end
    checkOutput("dp_a_held", dp_a, exp_dp_a);
    res_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    res_ready = 1'b0;
    checkOutput("post_in_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("post_res_valid", {31'd0, res_valid}, 32'd0);
    checkOutput("post_busy", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int lat;
    int hs[$];
    rst = 1'b0;
    in_a = '0; in_b = '0; in_valid = 1'b0; res_ready = 1'b0; dp_out1 = '0; dp_out2 = '0;
    b_in_a = 32'h0000_0007; b_in_b = 32'h0000_0009; b_in_valid = 1'b0; b_res_ready = 1'b0;
    b_dp_out1 = 32'h0000_0055; b_dp_out2 = 32'h0000_00AA;

    #3;
    checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_res_valid", {31'd0, res_valid}, 32'd0);
    checkOutput("rst_dp_a", dp_a, 32'd0);
    checkOutput("rst_res1", res1, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    $display("[TB] single inference with default latencies");
    applyStimulus(32'h0100_0000, 32'h0200_0000, 32'h0080_0000, 32'h0040_0000, 1'b0, lat);
    checkOutput("latency", lat, 32'd6);
    checkOutput("en_in_cycles", cnt_in, 32'd1);
    checkOutput("en_hid_cycles", cnt_hid, 32'd2);
    checkOutput("en_out_cycles", cnt_out, 32'd2);
    checkOutput("dp_b", dp_b, 32'h0200_0000);
    checkOutput("hold_en_out", {31'd0, en_out}, 32'd0);
    drainResult(10, 32'h0100_0000);

    $display("[TB] in_valid toggled while busy");
    applyStimulus(32'h0000_0011, 32'h0000_0022, 32'h1234_5678, 32'h8765_4321, 1'b1, lat);
    checkOutput("latency_toggle", lat, 32'd6);
    drainResult(3, 32'h0000_0011);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      @(negedge clk);
      checkOutput("no_second_result", {31'd0, res_valid}, 32'd0);
    end

    $display("[TB] reset during hidden layer");
    in_a = 32'h0000_0ABC; in_b = 32'h0000_0DEF; in_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    checkOutput("mid_en_hid", {31'd0, en_hid}, 32'd1);
    #2 rst = 1'b0;
    #1;
    checkOutput("mid_rst_en_hid", {31'd0, en_hid}, 32'd0);
    checkOutput("mid_rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("mid_rst_dp_a", dp_a, 32'd0);
    checkOutput("mid_rst_res1", res1, 32'd0);
    checkOutput("mid_rst_res_valid", {31'd0, res_valid}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      @(negedge clk);
      checkOutput("post_rst_res_valid", {31'd0, res_valid}, 32'd0);
      checkOutput("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    end

`ifdef ANN_CTRL_PERF_EN
    $display("[TB] performance counter");
    for (int n = 0; n < 3; n++) begin
      applyStimulus(32'(n), 32'(n + 1), 32'(n + 100), 32'(n + 200), 1'b0, lat);
      drainResult(0, 32'(n));
    end
    checkOutput("perf_cnt_3", perf_cnt, 32'd3);
    force dut.perf_cnt_q = 32'hFFFF_FFFF;
    @(posedge clk); @(negedge clk);
    release dut.perf_cnt_q;
    applyStimulus(32'h5, 32'h6, 32'h7, 32'h8, 1'b0, lat);
    drainResult(0, 32'h5);
    checkOutput("perf_cnt_wrap", perf_cnt, 32'd0);
`endif

    $display("[TB] back-to-back with unit latencies");
    b_in_valid = 1'b1;
    b_res_ready = 1'b1;
    for (int e = 1; e <= 30; e++) begin
      @(posedge clk);
      @(negedge clk);
      if (b_res_valid) begin
        hs.push_back(e);
        checkOutput("b2b_res1", b_res1, 32'h0000_0055);
        checkOutput("b2b_res2", b_res2, 32'h0000_00AA);
      end
    end
    b_in_valid = 1'b0;
    checkOutput("b2b_count", hs.size(), 32'd6);
    for (int i = 1; i < hs.size(); i++) begin
      checkOutput("b2b_interval", 32'(hs[i] - hs[i-1]), 32'd5);
    end
    checkOutput("b2b_dp_a", b_dp_a, 32'h0000_0007);

    checkOutput("sb_empty", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
